// File: rtl/timer_apb_slave.sv
// APB register-file responder for the 8-bit timer (TDR, TCR, TSR, TCNT view).
// Optional pslverr reporting is enabled by defining TIMER_APB_SLVERR_EN.
module timer_apb_slave #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [7:0]        pwdata,
    output logic [7:0]        prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        tdr_o,
    output logic              load_o,
    output logic              updown_o,
    output logic              en_o,
    output logic [1:0]        cks_o,
    input  logic [7:0]        tcnt_i,
    input  logic              ovf_i,
    input  logic              udf_i
);

    localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(2'd0);
    localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(2'd1);
    localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(2'd2);
    localparam logic [ADDR_W-1:0] A_TCNT = ADDR_W'(2'd3);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tdr;
    logic [7:0]        r_tcr;
    logic [1:0]        r_tsr;
    logic              r_load;
    logic              w_setup;
    logic              w_ready;
    logic              w_err;
    logic              w_commit;
    logic [7:0]        w_rdata;

    assign w_setup  = (r_state == ST_IDLE) && psel && !penable;
    assign w_ready  = (r_state == ST_ACCESS) && psel && penable && (r_wait == 3'(WAIT_STATES));
`ifdef TIMER_APB_SLVERR_EN
    assign w_err    = (r_addr > A_TCNT) || (r_write && (r_addr == A_TCNT));
`else
    assign w_err    = 1'b0;
`endif
    assign w_commit = w_ready && r_write && !w_err;

    // State register
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an access with psel dropped is abandoned without commit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_setup) w_state_nxt = ST_ACCESS;
                else         w_state_nxt = ST_IDLE;
            end
            ST_ACCESS: begin
                if (!psel || w_ready) w_state_nxt = ST_IDLE;
                else                  w_state_nxt = ST_ACCESS;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Setup-phase capture and wait-state counter
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_wait  <= 3'd0;
            r_addr  <= A_TDR;
            r_write <= 1'b0;
            r_wdata <= 8'h00;
        end else if (w_setup) begin
            r_wait  <= 3'd0;
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
        end else if ((r_state == ST_ACCESS) && psel && penable && !w_ready) begin
            r_wait  <= r_wait + 3'd1;
        end
    end

    // Register file; status set events take priority over a same-cycle W1C
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_tdr  <= 8'h00;
            r_tcr  <= 8'h00;
            r_tsr  <= 2'b00;
            r_load <= 1'b0;
        end else begin
            if (w_commit && (r_addr == A_TDR)) r_tdr <= r_wdata;
            if (w_commit && (r_addr == A_TCR)) r_tcr <= r_wdata & 8'h33;
            r_load   <= w_commit && (r_addr == A_TCR) && r_wdata[7];
            r_tsr[0] <= ovf_i | (r_tsr[0] & ~(w_commit && (r_addr == A_TSR) && r_wdata[0]));
            r_tsr[1] <= udf_i | (r_tsr[1] & ~(w_commit && (r_addr == A_TSR) && r_wdata[1]));
        end
    end

    // Read-data mux, driven only during a completing read
    always_comb begin
        w_rdata = 8'h00;
        if (w_ready && !r_write && !w_err) begin
            case (r_addr)
                A_TDR:   w_rdata = r_tdr;
                A_TCR:   w_rdata = r_tcr;
                A_TSR:   w_rdata = {6'b000000, r_tsr};
                A_TCNT:  w_rdata = tcnt_i;
                default: w_rdata = 8'h00;
            endcase
        end else begin
            w_rdata = 8'h00;
        end
    end

    assign prdata   = w_rdata;
    assign pready   = w_ready;
    assign pslverr  = w_ready && w_err;
    assign tdr_o    = r_tdr;
    assign load_o   = r_load;
    assign updown_o = r_tcr[5];
    assign en_o     = r_tcr[4];
    assign cks_o    = r_tcr[1:0];

endmodule

// File: tb/tb_timer_apb_slave.sv
// Self-checking bench for timer_apb_slave: one instance with 0 wait states,
// one with 3, both compared against a register-level reference model.
module tb_timer_apb_slave;

    logic       pclk = 1'b0;
    logic       prst;
    logic [1:0] psel;
    logic       penable, pwrite;
    logic [7:0] paddr, pwdata, tcnt_i;
    logic       ovf_i, udf_i;
    logic [7:0] rd0, rd1, tdr0, tdr1;
    logic [1:0] rdy_s, err_s, load_s, ud_s, en_s;
    logic [1:0] cks0, cks1;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_tdr [2];
    logic [7:0] m_tcr [2];
    logic [7:0] m_tsr [2];

    always #5 pclk = ~pclk;

    timer_apb_slave #(.WAIT_STATES(0), .ADDR_W(8)) u_dut0 (
        .pclk(pclk), .prst(prst), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(rd0), .pready(rdy_s[0]), .pslverr(err_s[0]),
        .tdr_o(tdr0), .load_o(load_s[0]), .updown_o(ud_s[0]), .en_o(en_s[0]), .cks_o(cks0),
        .tcnt_i(tcnt_i), .ovf_i(ovf_i), .udf_i(udf_i));

    timer_apb_slave #(.WAIT_STATES(3), .ADDR_W(8)) u_dut1 (
        .pclk(pclk), .prst(prst), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(rd1), .pready(rdy_s[1]), .pslverr(err_s[1]),
        .tdr_o(tdr1), .load_o(load_s[1]), .updown_o(ud_s[1]), .en_o(en_s[1]), .cks_o(cks1),
        .tcnt_i(tcnt_i), .ovf_i(ovf_i), .udf_i(udf_i));

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic wr, input logic [7:0] a);
`ifdef TIMER_APB_SLVERR_EN
        return (a > 8'd3) || (wr && (a == 8'd3));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [7:0] exp_read(input int d, input logic [7:0] a);
        if (exp_err(1'b0, a)) return 8'h00;
        case (a)
            8'd0:    return m_tdr[d];
            8'd1:    return m_tcr[d];
            8'd2:    return m_tsr[d];
            8'd3:    return tcnt_i;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input int d, input logic [7:0] a, input logic [7:0] v);
        if (!exp_err(1'b1, a)) begin
            if (a == 8'd0) m_tdr[d] = v;
            if (a == 8'd1) m_tcr[d] = v & 8'h33;   // LD and reserved bits never read back
            if (a == 8'd2) m_tsr[d] = m_tsr[d] & ~(v & 8'h03);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_tdr[d] = 8'h00; m_tcr[d] = 8'h00; m_tsr[d] = 8'h00;
        end
    endtask

    function automatic int tdr_of(input int d);
        return (d == 0) ? int'(tdr0) : int'(tdr1);
    endfunction

    // ---------------- bus driver (no checking) ----------------
    // Entered and left at posedge+1; leaves psel low so a following call is back-to-back.
    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] v,
                            input logic udf_at_ready, output logic [7:0] rdata, output int lat,
                            output logic err, output logic ok, output logic idle_bad);
        psel = (d == 0) ? 2'b01 : 2'b10;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = v;
        ok = 1'b0; rdata = 8'h00; err = 1'b0; idle_bad = 1'b0;
        @(posedge pclk); #1;
        penable = 1'b1; lat = 2;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (rdy_s[d]) begin
                ok = 1'b1;
                rdata = (d == 0) ? rd0 : rd1;
                err = err_s[d];
                if (udf_at_ready) udf_i = 1'b1;
                break;
            end
            if (((d == 0) ? rd0 : rd1) !== 8'h00) idle_bad = 1'b1;
            @(posedge pclk); #1;
            lat++;
        end
        @(posedge pclk); #1;
        psel = 2'b00; penable = 1'b0; udf_i = 1'b0;
    endtask

    task automatic pulse(input logic ovf, input logic udf);
        ovf_i = ovf; udf_i = udf;
        @(posedge pclk); #1;
        ovf_i = 1'b0; udf_i = 1'b0;
        for (int d = 0; d < 2; d++) m_tsr[d] = m_tsr[d] | {6'b000000, udf, ovf};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] rd; int lat; logic er, ok, ib;
        prst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00; tcnt_i = 8'h00; ovf_i = 1'b0; udf_i = 1'b0;
        model_reset();
        repeat (3) @(posedge pclk);
        #1 prst = 1'b0;
        @(negedge pclk);
        checks++;
        if ({rdy_s, err_s, load_s, ud_s, en_s, cks0, cks1, tdr0, tdr1, rd0, rd1} !== 46'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected all zero",
                {rdy_s, err_s, load_s, ud_s, en_s, cks0, cks1, tdr0, tdr1, rd0, rd1});
        end
        @(posedge pclk); #1;
        for (int a = 0; a < 4; a++) begin
            apb_xfer(0, 1'b0, 8'(a), 8'h00, 1'b0, rd, lat, er, ok, ib);
            checks++;
            if (!ok || rd !== 8'h00 || lat != 2 || ib) begin
                errors++; $display("FAIL reset_read a=%0d: got data=%h lat=%0d ok=%b, expected 00 lat=2", a, rd, lat, ok);
            end
        end
    endtask

    task automatic test_rw();
        logic [7:0] rd; int lat; logic er, ok, ib;
        apb_xfer(0, 1'b1, 8'h00, 8'hA5, 1'b0, rd, lat, er, ok, ib); model_write(0, 8'h00, 8'hA5);
        apb_xfer(0, 1'b1, 8'h01, 8'h33, 1'b0, rd, lat, er, ok, ib); model_write(0, 8'h01, 8'h33);
        apb_xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'hA5) begin errors++; $display("FAIL rw_tdr: got %h expected a5", rd); end
        apb_xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'h33) begin errors++; $display("FAIL rw_tcr: got %h expected 33", rd); end
        checks++;
        if (tdr0 !== 8'hA5 || en_s[0] !== 1'b1 || ud_s[0] !== 1'b1 || cks0 !== 2'b11) begin
            errors++; $display("FAIL rw_outputs: tdr=%h en=%b ud=%b cks=%b expected a5 1 1 11", tdr0, en_s[0], ud_s[0], cks0);
        end
    endtask

    task automatic test_load();
        logic [7:0] rd; int lat; logic er, ok, ib;
        apb_xfer(0, 1'b1, 8'h01, 8'h90, 1'b0, rd, lat, er, ok, ib); model_write(0, 8'h01, 8'h90);
        @(negedge pclk);
        checks++;
        if (load_s[0] !== 1'b1) begin errors++; $display("FAIL load_pulse: got %b expected 1", load_s[0]); end
        @(negedge pclk);
        checks++;
        if (load_s[0] !== 1'b0) begin errors++; $display("FAIL load_width: got %b expected 0", load_s[0]); end
        @(posedge pclk); #1;
        apb_xfer(0, 1'b0, 8'h01, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== exp_read(0, 8'h01) || rd !== 8'h10) begin
            errors++; $display("FAIL load_tcr_read: got %h expected 10", rd);
        end
    endtask

    task automatic test_tsr();
        logic [7:0] rd; int lat; logic er, ok, ib;
        pulse(1'b1, 1'b0);
        apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("FAIL tsr_ovf_set: got %h expected 01", rd); end
        apb_xfer(0, 1'b1, 8'h02, 8'hFE, 1'b0, rd, lat, er, ok, ib); model_write(0, 8'h02, 8'hFE);
        apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'h01) begin errors++; $display("FAIL tsr_w0_noeffect: got %h expected 01", rd); end
        apb_xfer(0, 1'b1, 8'h02, 8'h01, 1'b0, rd, lat, er, ok, ib); model_write(0, 8'h02, 8'h01);
        apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'h00) begin errors++; $display("FAIL tsr_w1c: got %h expected 00", rd); end
        apb_xfer(0, 1'b1, 8'h02, 8'h02, 1'b1, rd, lat, er, ok, ib);
        model_write(0, 8'h02, 8'h02);
        for (int d = 0; d < 2; d++) m_tsr[d] = m_tsr[d] | 8'h02;
        apb_xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'h02) begin errors++; $display("FAIL tsr_set_wins: got %h expected 02", rd); end
    endtask

    task automatic test_wait_states();
        logic [7:0] rd; int lat; logic er, ok, ib;
        apb_xfer(1, 1'b1, 8'h00, 8'h3C, 1'b0, rd, lat, er, ok, ib); model_write(1, 8'h00, 8'h3C);
        checks++;
        if (!ok || lat != 5) begin errors++; $display("FAIL ws_write_latency: got %0d expected 5", lat); end
        apb_xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (!ok || lat != 5 || rd !== 8'h3C || ib) begin
            errors++; $display("FAIL ws_read: got data=%h lat=%0d idle_nz=%b expected 3c lat=5", rd, lat, ib);
        end
        // abort: psel drops after two access cycles
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
        repeat (1) begin @(posedge pclk); #1; end
        penable = 1'b1;
        repeat (2) begin @(posedge pclk); #1; end
        psel = 2'b00; penable = 1'b0;
        repeat (2) begin @(posedge pclk); #1; end
        apb_xfer(1, 1'b0, 8'h00, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== m_tdr[1] || tdr_of(1) != int'(m_tdr[1])) begin
            errors++; $display("FAIL ws_abort: got rd=%h tdr_o=%h expected %h", rd, tdr1, m_tdr[1]);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] rd; int lat; logic er, ok, ib;
        apb_xfer(0, 1'b1, 8'h07, 8'h55, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (!ok || er !== exp_err(1'b1, 8'h07)) begin
            errors++; $display("FAIL illegal_write_err: got %b expected %b", er, exp_err(1'b1, 8'h07));
        end
        apb_xfer(0, 1'b1, 8'h03, 8'h55, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (!ok || er !== exp_err(1'b1, 8'h03)) begin
            errors++; $display("FAIL tcnt_write_err: got %b expected %b", er, exp_err(1'b1, 8'h03));
        end
        for (int a = 0; a < 3; a++) begin
            apb_xfer(0, 1'b0, 8'(a), 8'h00, 1'b0, rd, lat, er, ok, ib);
            checks++;
            if (rd !== exp_read(0, 8'(a))) begin
                errors++; $display("FAIL illegal_unchanged a=%0d: got %h expected %h", a, rd, exp_read(0, 8'(a)));
            end
        end
        apb_xfer(0, 1'b0, 8'h07, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (rd !== 8'h00 || er !== exp_err(1'b0, 8'h07)) begin
            errors++; $display("FAIL illegal_read: got data=%h err=%b expected 00 %b", rd, er, exp_err(1'b0, 8'h07));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; int lat; logic er, ok, ib;
        apb_xfer(0, 1'b1, 8'h00, 8'h11, 1'b0, rd, lat, er, ok, ib); model_write(0, 8'h00, 8'h11);
        apb_xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, rd, lat, er, ok, ib);
        checks++;
        if (!ok || rd !== 8'h11 || lat != 2) begin
            errors++; $display("FAIL b2b_read: got data=%h lat=%0d expected 11 lat=2", rd, lat);
        end
    endtask

    task automatic test_random();
        logic [7:0] rd, a, v, exp; int lat; logic er, ok, ib, wr;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            a = 8'($urandom_range(0, 7));
            v = 8'($urandom);
            wr = 1'($urandom_range(0, 1));
            tcnt_i = 8'($urandom);
            exp = exp_read(0, a);
            apb_xfer(0, wr, a, v, 1'b0, rd, lat, er, ok, ib);
            checks++;
            if (!ok || lat != 2 || ib || er !== exp_err(wr, a) || (!wr && rd !== exp)) begin
                errors++; $display("FAIL random n=%0d a=%h wr=%b: got data=%h err=%b lat=%0d expected %h %b 2",
                    n, a, wr, rd, er, lat, exp, exp_err(wr, a));
            end
            if (wr) model_write(0, a, v);
        end
        @(negedge pclk);
        checks++;
        if (tdr0 !== m_tdr[0] || {ud_s[0], en_s[0], cks0} !== {m_tcr[0][5], m_tcr[0][4], m_tcr[0][1:0]}) begin
            errors++; $display("FAIL random_outputs: tdr=%h ud=%b en=%b cks=%b expected tcr=%h tdr=%h",
                tdr0, ud_s[0], en_s[0], cks0, m_tcr[0], m_tdr[0]);
        end
        @(posedge pclk); #1;
    endtask

    task automatic test_reset_mid();
        psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'hC3;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b0;
        model_reset();
        @(negedge pclk);
        checks++;
        if (rdy_s[1] !== 1'b0 || tdr1 !== 8'h00) begin
            errors++; $display("FAIL reset_mid: got pready=%b tdr=%h expected 0 00", rdy_s[1], tdr1);
        end
        @(posedge pclk); #1;
        psel = 2'b00; penable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rw();
        test_load();
        test_tsr();
        test_wait_states();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_apb_slave.md
Name: timer_apb_slave

Overview:
APB responder (slave) holding the register file of the 8-bit timer: TDR, TCR, TSR and a read-only TCNT view. It sits between the CPU-side APB bus and the timer counter core. It decodes transfers, inserts configurable wait states and drives the control outputs to the core. It also captures the core's overflow and underflow events into sticky, write-1-to-clear status bits.

Parameters:
WAIT_STATES, 0, number of extra ACCESS cycles before pready rises (legal 0..7)
ADDR_W, 8, paddr width

Ports:
pclk  in  1  system clock, all logic on rising edge
prst  in  1  synchronous active-high reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  register address
pwdata  in  8  write data
prdata  out  8  read data, valid while pready=1, else 0
pready  out  1  transfer completion
pslverr  out  1  transfer error (see Optional Feature)
tdr_o  out  8  reload value to counter core
load_o  out  1  one-cycle load pulse to core
updown_o  out  1  TCR[5], 1 = count down
en_o  out  1  TCR[4], counter enable
cks_o  out  2  TCR[1:0], clock-select
tcnt_i  in  8  live counter value from core
ovf_i  in  1  overflow pulse from core
udf_i  in  1  underflow pulse from core

Behaviour:
- Reset (prst=1 at edge): FSM to IDLE; TDR=0x00, TCR=0x00, TSR=0x00; all outputs 0.
- Address map:
  - 0x00 TDR, R/W.
  - 0x01 TCR, R/W. Bits 7,5,4,1,0 implemented; bits 6,3,2 read 0.
  - 0x02 TSR, R/W1C. Bit0 OVF, bit1 UDF; bits 7:2 read 0.
  - 0x03 TCNT, read-only. Read returns tcnt_i; writes are ignored.
- FSM states IDLE, ACCESS:
  - IDLE -> ACCESS on psel=1 & penable=0 (setup phase). Latch paddr, pwrite, pwdata and clear the wait counter.
  - ACCESS: the wait counter increments each cycle while psel & penable. pready=1 (combinational) when psel & penable & wait counter == WAIT_STATES.
  - ACCESS -> IDLE on the completion cycle (pready=1), or immediately if psel drops (abort, no commit).
- Latency: with WAIT_STATES=0, a standard 2-cycle APB transfer completes in cycle 2. Each extra wait state adds exactly one cycle.
- Write commit: register updates at the clock edge ending the pready=1 cycle; never earlier.
- Read: prdata equals the register value in the pready=1 cycle and is 0 otherwise. The TCNT read samples tcnt_i in that cycle.
- TCR[7] (LD): writing 1 produces load_o=1 for exactly one cycle, the cycle after commit. LD is not stored and always reads 0.
- TSR status:
  - OVF sets on ovf_i=1 and UDF sets on udf_i=1, any cycle; both are sticky.
  - A write with pwdata bit=1 clears the corresponding bit; writing 0 has no effect.
  - Simultaneous set event and W1C clear in the same cycle: set wins, bit stays 1.
- Back-to-back transfers (new setup the cycle after completion) are supported with no idle gap.
- Reset mid-transfer: transfer discarded, no commit, pready=0 the next cycle.
- Outputs updown_o, en_o, cks_o, tdr_o are direct register bits, registered (no combinational path from APB inputs).

Optional Feature:
- Macro: TIMER_APB_SLVERR_EN.
- Defined: access to paddr > 0x03, or a write to 0x03, asserts pslverr=1 together with pready. No register changes; prdata=0.
- Undefined: pslverr tied 0; such accesses complete normally, reads return 0x00, writes are ignored.

Test Plan:
- Reset, then read 0x00..0x03 with tcnt_i=0x00 -> all read 0x00; pready high in cycle 2 of each transfer.
- Write TDR=0xA5 and TCR=0x33, read both back -> 0xA5 and 0x33; tdr_o=0xA5, en_o=1, updown_o=1, cks_o=2'b11.
- Write TCR=0x90 -> load_o high exactly one cycle after commit; TCR reads 0x10.
- Pulse ovf_i one cycle, read TSR -> 0x01. Write 0xFE -> still 0x01. Write 0x01 -> 0x00. Pulse udf_i in the same cycle as a W1C of 0x02 -> TSR reads 0x02.
- WAIT_STATES=3: write/read TDR -> pready rises 3 cycles after penable. Drop psel mid-access -> TDR unchanged.
- With TIMER_APB_SLVERR_EN: write 0x55 to 0x07 -> pslverr=1 with pready, all registers unchanged. Without the macro: pslverr=0 and a read of 0x07 returns 0x00.
